// File: rtl/stage8_window_reader_if.sv
// Stream/window bundle between the stage-8 delay chain, the window reader and
// the layer-6 PE array. The reader takes the slave side: it consumes the tap
// stream and produces the window, row/col anchor and frame-done strobe.
interface stage8_window_reader_if #(
   parameter int DATA_W = 128,
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8
);
   logic                       frame_start;
   logic                       in_valid;
   logic [DATA_W-1:0]          tap_top;
   logic [DATA_W-1:0]          tap_mid;
   logic [DATA_W-1:0]          tap_bot;
   logic                       out_valid;
   logic [9*DATA_W-1:0]        win_data;
   logic [$clog2(IMG_H)-1:0]   out_row;
   logic [$clog2(IMG_W)-1:0]   out_col;
   logic                       frame_done;

   modport master (
      output frame_start, in_valid, tap_top, tap_mid, tap_bot,
      input  out_valid, win_data, out_row, out_col, frame_done
   );

   modport slave (
      input  frame_start, in_valid, tap_top, tap_mid, tap_bot,
      output out_valid, win_data, out_row, out_col, frame_done
   );
endinterface

// File: rtl/stage8_window_reader.sv
// Stage-8 window reader: shifts the three delay-chain taps into a 3x3 window,
// tracks frame position and emits each in-bounds window one cycle after the
// pixel that completes it.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for frame_start, pixels ignored
// FILL  | accepting pixels, next position has row<2 or col<2
// RUN   | accepting pixels, next position has row>=2 and col>=2
// DONE  | last pixel of frame accepted, pixels ignored until frame_start
module stage8_window_reader #(
   parameter int DATA_W = 128,
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8
) (
   input logic                    clk,
   input logic                    rst,
   stage8_window_reader_if.slave  bus
);
   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
   localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
   localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
   localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

   typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

   state_t            state_q, state_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic              accept;
   logic              emit;
   logic              last;
   logic [DATA_W-1:0] win_q [9];
   logic              out_valid_q;
   logic              frame_done_q;
   logic [ROW_W-1:0]  out_row_q;
   logic [COL_W-1:0]  out_col_q;

   // Next state, position and accept/emit decode; frame_start overrides all.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      accept  = 1'b0;
      emit    = 1'b0;
      last    = 1'b0;
      if (bus.frame_start) begin
         state_d = FILL;
         col_d   = '0;
         row_d   = '0;
         if (bus.in_valid) begin
            // The coincident pixel is taken as (0,0); width >= 3 so no wrap.
            accept = 1'b1;
            col_d  = COL_ONE;
         end
      end else if ((state_q == FILL || state_q == RUN) && bus.in_valid) begin
         accept = 1'b1;
         emit   = (row_q >= ROW_TWO) && (col_q >= COL_TWO);
         if (col_q == COL_LAST) begin
            if (row_q == ROW_LAST) begin
               last    = 1'b1;
               state_d = DONE;
            end else begin
               col_d   = '0;
               row_d   = row_q + ROW_W'(1);
               state_d = FILL;
            end
         end else begin
            col_d   = col_q + COL_ONE;
            state_d = ((row_q >= ROW_TWO) && (col_q >= COL_ONE)) ? RUN : FILL;
         end
      end
   end

   // State and position registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         col_q   <= '0;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
      end
   end

   // Window shift on every accept, new column enters on the right.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < 9; k++) win_q[k] <= '0;
      end else if (accept) begin
         for (int r = 0; r < 3; r++) begin
            win_q[r*3]   <= win_q[r*3+1];
            win_q[r*3+1] <= win_q[r*3+2];
         end
         win_q[2] <= bus.tap_top;
         win_q[5] <= bus.tap_mid;
         win_q[8] <= bus.tap_bot;
      end
   end

   // Output strobes and anchor position, one cycle behind the accept.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         out_row_q    <= '0;
         out_col_q    <= '0;
      end else begin
         out_valid_q  <= emit;
         frame_done_q <= last;
         if (emit) begin
            out_row_q <= row_q;
            out_col_q <= col_q;
         end
      end
   end

   genvar gk;
   generate
      for (gk = 0; gk < 9; gk++) begin : g_pack
         assign bus.win_data[gk*DATA_W +: DATA_W] = win_q[gk];
      end
   endgenerate

   assign bus.out_valid  = out_valid_q;
   assign bus.frame_done = frame_done_q;
   assign bus.out_row    = out_row_q;
   assign bus.out_col    = out_col_q;
endmodule

// File: tb/tb_stage8_window_reader.sv
// Bench for the stage-8 window reader on a 4x4 frame with 16-bit pixels.
module tb_stage8_window_reader;
   localparam int DW = 16;
   localparam int W  = 4;
   localparam int H  = 4;
   localparam int WINW = 9*DW;

   typedef struct {
      int             row;
      int             col;
      bit             done;
      logic [WINW-1:0] win;
   } win_rec_t;

   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   fd_cnt   = 0;
   int   gap_viol = 0;
   win_rec_t exp_tab [4];
   win_rec_t got_q [$];

   stage8_window_reader_if #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) bus ();

   stage8_window_reader #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Collect emitted windows; flag any out_valid not preceded by in_valid.
   always @(posedge clk) begin
      logic iv_edge;
      iv_edge = bus.in_valid;
      #1;
      if (bus.out_valid) begin
         got_q.push_back('{int'(bus.out_row), int'(bus.out_col), bus.frame_done, bus.win_data});
         if (!iv_edge) gap_viol++;
      end
      if (bus.frame_done) fd_cnt++;
   end

   function automatic logic [WINW-1:0] mkwin(input int s0, s1, s2, s3, s4, s5, s6, s7, s8);
      int s [9];
      logic [WINW-1:0] w;
      s = '{s0, s1, s2, s3, s4, s5, s6, s7, s8};
      w = '0;
      for (int k = 0; k < 9; k++) w[k*DW +: DW] = DW'(s[k]);
      return w;
   endfunction

   task automatic chk(input string name, input logic [WINW-1:0] act, input logic [WINW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " out_valid"},  WINW'(bus.out_valid),  '0);
      chk({tag, " frame_done"}, WINW'(bus.frame_done), '0);
      chk({tag, " win_data"},   bus.win_data,          '0);
      chk({tag, " out_row"},    WINW'(bus.out_row),    '0);
      chk({tag, " out_col"},    WINW'(bus.out_col),    '0);
   endtask

   task automatic idle(input int n, input bit fs = 1'b0);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.frame_start = fs;
         bus.in_valid    = 1'b0;
      end
   endtask

   task automatic drive_px(input int r, input int c, input bit fs);
      int p;
      p = r*W + c;
      @(negedge clk);
      bus.frame_start = fs;
      bus.in_valid    = 1'b1;
      bus.tap_bot     = DW'(p);
      bus.tap_mid     = DW'(p - 4);
      bus.tap_top     = DW'(p - 8);
   endtask

   task automatic send_frame(input bit gap);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            drive_px(r, c, 1'b0);
            if (gap) idle(1);
         end
      idle(3);
   endtask

   task automatic clear_obs();
      got_q.delete();
      fd_cnt   = 0;
      gap_viol = 0;
   endtask

   // Compare captured windows to n_prefix leading (2,2) windows plus the full table.
   task automatic check_frame(input string tag, input int n_prefix);
      win_rec_t exp_q [$];
      int n;
      for (int i = 0; i < n_prefix; i++) exp_q.push_back(exp_tab[0]);
      for (int i = 0; i < 4; i++) exp_q.push_back(exp_tab[i]);
      chk({tag, " window count"}, WINW'(got_q.size()), WINW'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s w%0d row", tag, i),  WINW'(got_q[i].row),  WINW'(exp_q[i].row));
         chk($sformatf("%s w%0d col", tag, i),  WINW'(got_q[i].col),  WINW'(exp_q[i].col));
         chk($sformatf("%s w%0d done", tag, i), WINW'(got_q[i].done), WINW'(exp_q[i].done));
         chk($sformatf("%s w%0d data", tag, i), got_q[i].win,         exp_q[i].win);
      end
      chk({tag, " frame_done pulses"}, WINW'(fd_cnt), WINW'(1));
      chk({tag, " out_valid after gap"}, WINW'(gap_viol), '0);
      clear_obs();
   endtask

   task automatic abort_frame(input string tag, input int k, input int n_prefix);
      idle(1, 1'b1);
      for (int i = 0; i < k; i++) drive_px(i / W, i % W, 1'b0);
      drive_px(0, 0, 1'b1);
      for (int i = 1; i < W*H; i++) drive_px(i / W, i % W, 1'b0);
      idle(3);
      check_frame(tag, n_prefix);
   endtask

   initial begin
      exp_tab[0] = '{2, 2, 1'b0, mkwin(0, 1, 2, 4, 5, 6, 8, 9, 10)};
      exp_tab[1] = '{2, 3, 1'b0, mkwin(1, 2, 3, 5, 6, 7, 9, 10, 11)};
      exp_tab[2] = '{3, 2, 1'b0, mkwin(4, 5, 6, 8, 9, 10, 12, 13, 14)};
      exp_tab[3] = '{3, 3, 1'b1, mkwin(5, 6, 7, 9, 10, 11, 13, 14, 15)};

      bus.frame_start = 1'b0;
      bus.in_valid    = 1'b0;
      bus.tap_top     = '0;
      bus.tap_mid     = '0;
      bus.tap_bot     = '0;
      rst = 1'b1;
      #3 rst = 1'b0;
      #2 chk_zero("reset");
      @(negedge clk);
      rst = 1'b1;

      // Pixels before any frame_start must not produce windows.
      for (int i = 0; i < 5; i++) drive_px(1, i % W, 1'b0);
      idle(3);
      chk("idle no windows", WINW'(got_q.size()), '0);
      clear_obs();

      // Back-to-back full frame.
      idle(1, 1'b1);
      send_frame(1'b0);
      check_frame("full", 0);

      // DONE holds: extra pixels produce nothing.
      for (int i = 0; i < 5; i++) drive_px(0, i % W, 1'b0);
      idle(3);
      chk("done hold windows", WINW'(got_q.size()), '0);
      chk("done hold frame_done", WINW'(fd_cnt), '0);
      clear_obs();

      // Restart with in_valid toggling.
      idle(1, 1'b1);
      send_frame(1'b1);
      check_frame("gapped", 0);

      // Restart coincident with a pixel mid-frame.
      abort_frame("abort6", 6, 0);
      abort_frame("abort11", 11, 1);

      // Asynchronous reset mid-frame with a window on the outputs.
      idle(1, 1'b1);
      for (int i = 0; i < 11; i++) drive_px(i / W, i % W, 1'b0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      #2 rst = 1'b0;
      #1 chk_zero("midreset");
      @(negedge clk);
      rst = 1'b1;
      clear_obs();
      for (int i = 0; i < 5; i++) drive_px(2, i % W, 1'b0);
      idle(3);
      chk("post reset idle windows", WINW'(got_q.size()), '0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
